gray_img_server: RTL and testbench



---
 rtl/gray_pkg.sv | 19 +
 rtl/gray_srv_ram.sv | 25 ++
 rtl/gray_img_server.sv | 108 ++++++++++
 tb/tb_gray_img_server.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and frame geometry for the gray-image server.
package gray_pkg;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int IMG_PIX = IMG_W * IMG_H;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } srv_state_t;

  typedef logic [7:0] pix_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gray_srv_ram.sv
// Frame store: one synchronous write port, one asynchronous read port.
module gray_srv_ram
  import gray_pkg::*;
#(
  parameter int DEPTH = IMG_PIX,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pix_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output pix_t          rdata_o
);

  pix_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Out-of-range reads return zero rather than an undefined entry.
  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/gray_img_server.sv
// Buffers one grayscale frame from a valid/ready stream, then serves random reads until finish.
// Optional read counter port rd_cnt is built when GRAY_SRV_STATS_EN is defined.
module gray_img_server
  import gray_pkg::*;
#(
  parameter int WIDTH  = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [7:0]        gray_data,
  input  logic              finish,
  output logic [7:0]        frame_cnt
`ifdef GRAY_SRV_STATS_EN
  ,
  output logic [15:0]       rd_cnt
`endif
);

  localparam int                NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W + 1)'(NPIX);

  srv_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        frame_q, frame_d;
  logic              wr_en;
  logic              addr_ok;
  pix_t              rd_pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_valid && wr_ptr_q == LAST) state_d = SERVE;
      SERVE:   if (finish) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == LOAD);
    gray_ready = (state_q == SERVE);
    wr_en      = (state_q == LOAD) && in_valid;
  end

  // Pointer wraps to zero on the last pixel so the next frame starts clean.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    frame_d  = frame_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (state_q == SERVE && finish) frame_d = frame_q + 8'd1;
  end

  assign frame_cnt = frame_q;
  assign addr_ok   = ({1'b0, gray_addr} < LIM);
  assign gray_data = (gray_ready && gray_req && addr_ok) ? rd_pix : 8'd0;

  gray_srv_ram #(
    .DEPTH (NPIX),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (gray_addr),
    .rdata_o (rd_pix)
  );

`ifdef GRAY_SRV_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (state_q == SERVE) begin
      if (finish)        rd_cnt_d = '0;
      else if (gray_req) rd_cnt_d = sat_inc16(rd_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_cnt_q <= '0;
    else       rd_cnt_q <= rd_cnt_d;
  end

  assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_gray_img_server.sv
// Randomized bench for gray_img_server against a frame-level reference model.
module tb_gray_img_server;

  localparam int PIX = 128 * 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        finish;
  logic [7:0]  frame_cnt;
`ifdef GRAY_SRV_STATS_EN
  logic [15:0] rd_cnt;
`endif

  gray_img_server dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .finish     (finish),
    .frame_cnt  (frame_cnt)
`ifdef GRAY_SRV_STATS_EN
    ,
    .rd_cnt     (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a byte array plus a fill count; serving is a flag.
  byte unsigned m_mem [PIX];
  int           m_cnt;
  bit           m_serve;
  int           m_frames;
  int           m_rd;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_serve = 0; m_frames = 0; m_rd = 0;
      chk_en = 1'b1;
    end else if (!m_serve) begin
      if (in_valid) begin
        m_mem[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == PIX) begin
          m_serve = 1;
          m_cnt   = 0;
        end
      end
    end else begin
      if (gray_req && m_rd < 65535) m_rd++;
      if (finish) begin
        m_serve  = 0;
        m_frames = (m_frames + 1) % 256;
        m_rd     = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("in_ready", in_ready, !m_serve);
      chk("gray_ready", gray_ready, m_serve);
      chk("frame_cnt", frame_cnt, m_frames);
      chk("gray_data", gray_data,
          (m_serve && gray_req && int'(gray_addr) < PIX) ? m_mem[gray_addr] : 8'd0);
`ifdef GRAY_SRV_STATS_EN
      chk("rd_cnt", rd_cnt, m_rd);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = 0; gray_req = 0; gray_addr = 0; finish = 0;
    step(); step();
    reset = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_gray_data", gray_data, 0);
`ifdef GRAY_SRV_STATS_EN
    chk("rst_rd_cnt", rd_cnt, 0);
`endif
    gray_req = 1; gray_addr = 14'd5;
    #1 chk("load_rd_zero", gray_data, 0);
    gray_req = 0;
    step();

    // Frame 1: ramp with in_valid held high.
    in_valid = 1;
    for (int i = 0; i < PIX; i++) begin
      in_data = 8'(i);
      if (i == PIX - 1) begin
        @(negedge clk);
        chk("ramp_not_ready_yet", gray_ready, 0);
      end
      step();
    end
    in_valid = 0;
    chk("ramp_ready", gray_ready, 1);
    chk("ramp_in_ready_low", in_ready, 0);
    gray_req = 1; gray_addr = 14'd129;
    #1 chk("rd_129", gray_data, 8'd129);
    gray_addr = 14'd16383;
    #1 chk("rd_16383", gray_data, 8'hFF);
    gray_req = 0; gray_addr = 14'd5;
    #1 chk("rd_noreq", gray_data, 0);
    step();
    for (int i = 0; i < 200; i++) begin
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = 14'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      step();
    end
    in_valid = 0;
    gray_req = 1; gray_addr = 14'd77; finish = 1;
    #1 chk("finish_rd", gray_data, 8'd77);
    step();
    finish = 0; gray_req = 0;
    chk("fin_gray_ready", gray_ready, 0);
    chk("fin_in_ready", in_ready, 1);
    chk("fin_frame_cnt", frame_cnt, 1);

    // Partial load, reset, then a full frame of 8'hA5.
    in_valid = 1; in_data = 8'h3C;
    for (int i = 0; i < 100; i++) step();
    in_valid = 0; reset = 1;
    step();
    reset = 0;
    chk("rst2_frame_cnt", frame_cnt, 0);
    in_valid = 1; in_data = 8'hA5;
    for (int i = 0; i < PIX; i++) begin
      if (i == PIX - 1) begin
        @(negedge clk);
        chk("reload_not_ready_yet", gray_ready, 0);
      end
      step();
    end
    in_valid = 0;
    chk("reload_ready", gray_ready, 1);
    gray_req = 1; gray_addr = 14'd0;
    #1 chk("a5_addr0", gray_data, 8'hA5);
    gray_addr = 14'd16383;
    #1 chk("a5_addr_last", gray_data, 8'hA5);
    for (int i = 0; i < 300; i++) begin
      gray_req  = 1;
      gray_addr = 14'($urandom);
      step();
    end
    gray_req = 0;
`ifdef GRAY_SRV_STATS_EN
    chk("rd_cnt_300", rd_cnt, 300);
`endif
    finish = 1;
    step();
    finish = 0;
    chk("fin2_frame_cnt", frame_cnt, 1);
`ifdef GRAY_SRV_STATS_EN
    chk("rd_cnt_clear", rd_cnt, 0);
`endif

    // Frame 3: random data, in_valid toggling every cycle, then a full sweep.
    for (int i = 0; i < 2 * PIX; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 0;
    chk("toggle_ready", gray_ready, 1);
    for (int a = 0; a < PIX; a++) begin
      gray_req  = 1;
      gray_addr = 14'(a);
      step();
    end
    for (int i = 0; i < 50; i++) begin
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = 14'($urandom);
      finish    = (i == 49);
      step();
    end
    finish = 0; gray_req = 0;
    chk("fin3_frame_cnt", frame_cnt, 2);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
